seq_normalizer: RTL and testbench

//  Multi-cycle leading-zero normalizer: the inverse of the team's variable shifter.
//  - Accepts a WIDTH-bit word.
//  - Shifts it left one bit per cycle until the MSB is 1.
//  - Returns the normalized word, the shift amount and a zero flag.
//  - The shift amount uses the same encoding as the shifter's sel input. Right-shifting
//    out_data by out_shamt recovers in_data.
//  - Sits between the datapath producer and the shifter/rescale stage, valid/ready on both sides.

---
 rtl/norm_pkg.sv | 22 ++
 rtl/seq_normalizer.sv | 110 +++++++++++
 tb/tb_seq_normalizer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/norm_pkg.sv
// rtl/norm_pkg.sv - shared state type and width helper for the leading-zero normalizer
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_normalizer.sv
// rtl/seq_normalizer.sv - one-bit-per-cycle leading-zero normalizer with valid/ready on both sides
module seq_normalizer
    import norm_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_shamt,
    output logic             out_zero
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // in_ready is the only combinational output so it drops with rst_n immediately
    assign in_ready = rst_n && (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (in_data == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (sreg[WIDTH-1]) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg <= in_data;
                        cnt  <= '0;
                        // all-zero input has no leading one; report it straight away
                        if (in_data == '0) begin
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_shamt <= '0;
                            out_zero  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (sreg[WIDTH-1]) begin
                        out_valid <= 1'b1;
                        out_data  <= sreg;
                        out_shamt <= cnt;
                        out_zero  <= 1'b0;
                    end else begin
                        sreg <= sreg << 1;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // a zero word in SHIFT would never find its leading one
    sreg_nonzero_in_shift: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SHIFT) |-> (sreg != '0));

endmodule

// File: tb/tb_seq_normalizer.sv
// tb/tb_seq_normalizer.sv - self-checking bench for seq_normalizer
module tb_seq_normalizer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   out_shamt;
    logic         out_zero;

    seq_normalizer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shamt (out_shamt),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] data;
        logic [2:0]   shamt;
        logic         zero;
    } exp_t;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] data;
        logic [2:0]   shamt;
        logic         zero;
        int           lat;
        int           hold;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   rand_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // reference: locate the highest set bit and derive the shift from its position
    function automatic exp_t model(input logic [W-1:0] d);
        exp_t e;
        int   p;
        p = -1;
        for (int i = 0; i < W; i++) if (d[i]) p = i;
        e.din  = d;
        e.zero = (d == '0);
        if (p < 0) begin
            e.shamt = 3'd0;
            e.data  = '0;
        end else begin
            e.shamt = 3'(W - 1 - p);
            e.data  = d << (W - 1 - p);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = 8'($urandom);
        if ($urandom_range(0, 15) == 0) return '0;
        return w >> $urandom_range(0, 7);
    endfunction

    // scoreboard monitor: push on accept, pop on output handshake, watch hold stability
    initial begin
        exp_t         e;
        bit           held;
        logic [W-1:0] h_data;
        logic [2:0]   h_shamt;
        logic         h_zero;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (in_valid && in_ready) sb.push_back(model(in_data));
                if (out_valid) begin
                    if (held) begin
                        chk("hold_data", 32'(out_data), 32'(h_data));
                        chk("hold_shamt", 32'(out_shamt), 32'(h_shamt));
                        chk("hold_zero", 32'(out_zero), 32'(h_zero));
                    end
                    if (out_ready) begin
                        held = 1'b0;
                        if (sb.size() == 0) begin
                            timeout("unexpected_output");
                        end else begin
                            e = sb.pop_front();
                            chk("sb_data", 32'(out_data), 32'(e.data));
                            chk("sb_shamt", 32'(out_shamt), 32'(e.shamt));
                            chk("sb_zero", 32'(out_zero), 32'(e.zero));
                            chk("sb_recover", 32'(out_data >> out_shamt), 32'(e.din));
                            chk("sb_msb_rule", 32'(out_data[W-1] | out_zero), 32'd1);
                        end
                    end else begin
                        held    = 1'b1;
                        h_data  = out_data;
                        h_shamt = out_shamt;
                        h_zero  = out_zero;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    task automatic apply(input vec_t v);
        bit ok;
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = v.din;
        ok = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin timeout("accept"); return; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'hA5;
        lat = 0;
        for (int c = 1; c <= W + 4; c++) begin
            @(negedge clk);
            if (out_valid) begin lat = c; break; end
        end
        if (lat == 0) begin timeout("out_valid"); return; end
        chk("latency", 32'(lat), 32'(v.lat));
        chk("out_data", 32'(out_data), 32'(v.data));
        chk("out_shamt", 32'(out_shamt), 32'(v.shamt));
        chk("out_zero", 32'(out_zero), 32'(v.zero));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("held_valid", 32'(out_valid), 32'd1);
            chk("held_data", 32'(out_data), 32'(v.data));
            chk("held_shamt", 32'(out_shamt), 32'(v.shamt));
            chk("held_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_handshake", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after", 32'(in_ready), 32'd1);
        chk("valid_after", 32'(out_valid), 32'd0);
    endtask

    task automatic accept_one(input logic [W-1:0] d);
        bit ok;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        ok = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("accept_one");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int   lat;
        bit   ok;

        vecs.push_back('{din: 8'h01, data: 8'h80, shamt: 3'd7, zero: 1'b0, lat: 9, hold: 0});
        vecs.push_back('{din: 8'h80, data: 8'h80, shamt: 3'd0, zero: 1'b0, lat: 2, hold: 1});
        vecs.push_back('{din: 8'h00, data: 8'h00, shamt: 3'd0, zero: 1'b1, lat: 1, hold: 0});
        vecs.push_back('{din: 8'h2C, data: 8'hB0, shamt: 3'd2, zero: 1'b0, lat: 4, hold: 5});
        vecs.push_back('{din: 8'h0F, data: 8'hF0, shamt: 3'd4, zero: 1'b0, lat: 6, hold: 2});
        vecs.push_back('{din: 8'hFF, data: 8'hFF, shamt: 3'd0, zero: 1'b0, lat: 2, hold: 0});
        vecs.push_back('{din: 8'h03, data: 8'hC0, shamt: 3'd6, zero: 1'b0, lat: 8, hold: 3});
        vecs.push_back('{din: 8'h5A, data: 8'hB4, shamt: 3'd1, zero: 1'b0, lat: 3, hold: 1});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_shamt", 32'(out_shamt), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) apply(vecs[i]);

        // out_ready already high before the result appears
        out_ready = 1'b1;
        accept_one(8'h20);
        lat = 0;
        for (int c = 1; c <= W + 4; c++) begin
            @(negedge clk);
            if (out_valid) begin lat = c; break; end
        end
        chk("early_ready_lat", 32'(lat), 32'd4);
        chk("early_ready_data", 32'(out_data), 32'h80);
        chk("early_ready_shamt", 32'(out_shamt), 32'd2);
        @(negedge clk);
        chk("early_ready_valid", 32'(out_valid), 32'd0);
        chk("early_ready_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset during SHIFT
        accept_one(8'h04);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_shift_valid", 32'(out_valid), 32'd0);
        chk("rst_shift_in_ready", 32'(in_ready), 32'd0);
        chk("rst_shift_data", 32'(out_data), 32'd0);
        do_reset(2);
        v = '{din: 8'h40, data: 8'h80, shamt: 3'd1, zero: 1'b0, lat: 3, hold: 0};
        apply(v);

        // reset while a result waits in DONE
        accept_one(8'h10);
        ok = 1'b0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("done_wait");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_done_valid", 32'(out_valid), 32'd0);
        chk("rst_done_shamt", 32'(out_shamt), 32'd0);
        chk("rst_done_in_ready", 32'(in_ready), 32'd0);
        do_reset(2);
        apply(vecs[0]);

        // random traffic through the scoreboard
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin @(posedge clk); #1; end
                    @(posedge clk); #1;
                    in_valid = 1'b1;
                    in_data  = rand_word();
                    ok = 1'b0;
                    for (int c = 0; c < 64; c++) begin
                        @(negedge clk);
                        if (in_ready) begin ok = 1'b1; break; end
                    end
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    if (!ok) begin timeout("rand_accept"); break; end
                end
                ok = 1'b0;
                for (int c = 0; c < 200; c++) begin
                    @(negedge clk);
                    if (sb.size() == 0 && !out_valid) begin ok = 1'b1; break; end
                end
                if (!ok) timeout("rand_drain");
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b0;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
